// File: rtl/mem_bus_arbiter_if.sv
// Two-master data-memory bus: master request/response signals plus the memory side.
interface mem_bus_arbiter_if;
   logic        m0_req;
   logic        m0_we;
   logic        m0_lock;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_gnt;
   logic        m0_ack;
   logic        m0_err;
   logic [31:0] m0_rdata;

   logic        m1_req;
   logic        m1_we;
   logic        m1_lock;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_gnt;
   logic        m1_ack;
   logic        m1_err;
   logic [31:0] m1_rdata;

   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   // Arbiter side.
   modport slave (
      input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
      input  mem_rd,
      output m0_gnt, m0_ack, m0_err, m0_rdata,
      output m1_gnt, m1_ack, m1_err, m1_rdata,
      output mem_we, mem_a, mem_wd
   );

   // Requester / memory-model side.
   modport master (
      output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
      output mem_rd,
      input  m0_gnt, m0_ack, m0_err, m0_rdata,
      input  m1_gnt, m1_ack, m1_err, m1_rdata,
      input  mem_we, mem_a, mem_wd
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter: round-robin with bounded bus locking,
// address legality checking and registered single-cycle completions.
module mem_bus_arbiter #(
   parameter int unsigned MAX_LOCK = 4
) (
   input logic               clk,
   input logic               reset,
   mem_bus_arbiter_if.slave  bus
);
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);
   localparam logic [CW-1:0] SAT_CNT = {CW{1'b1}};

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t        state, state_nx;
   logic          last_grant, last_grant_nx;
   logic [CW-1:0] lock_cnt, lock_cnt_nx;

   logic          gnt0_c, gnt1_c;
   logic          gnt0, gnt1;
   logic          hold0, hold1, req0_arb, req1_arb;
   logic          legal0, legal1, legal_sel, we_sel;
   logic [DW-1:0] addr_sel, wdata_sel;

   logic          ack0, ack1, err0, err1;
   logic [DW-1:0] rdata0, rdata1;

   // RAM words below 0x100, read-only switches, write-only LEDs.
   function automatic logic is_legal(input logic [DW-1:0] a, input logic we);
      return ((a < 32'h0000_0100) && (a[1:0] == 2'b00)) ||
             ((a == 32'hC000_0000) && !we) ||
             ((a == 32'hC000_0004) && we);
   endfunction

   assign legal0 = is_legal(bus.m0_addr, bus.m0_we);
   assign legal1 = is_legal(bus.m1_addr, bus.m1_we);

   // Arbitration state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         lock_cnt   <= '0;
      end else begin
         state      <= state_nx;
         last_grant <= last_grant_nx;
         lock_cnt   <= lock_cnt_nx;
      end
   end

   // Grant selection and next-state logic.
   always_comb begin
      gnt0_c        = 1'b0;
      gnt1_c        = 1'b0;
      state_nx      = IDLE;
      last_grant_nx = last_grant;
      lock_cnt_nx   = '0;

      // The lock owner keeps the bus unless it has used its quota while the
      // other master waits; >= keeps that true if the count ran past the limit
      // while the other master was idle.
      hold0 = (state == LOCK0) && bus.m0_req && !((lock_cnt >= MAX_CNT) && bus.m1_req);
      hold1 = (state == LOCK1) && bus.m1_req && !((lock_cnt >= MAX_CNT) && bus.m0_req);

      // A lock owner that is not held is excluded from open arbitration.
      req0_arb = bus.m0_req && (state != LOCK0);
      req1_arb = bus.m1_req && (state != LOCK1);

      if (hold0) begin
         gnt0_c        = 1'b1;
         last_grant_nx = 1'b0;
         if (bus.m0_lock) begin
            state_nx    = LOCK0;
            lock_cnt_nx = (lock_cnt == SAT_CNT) ? lock_cnt : CW'(lock_cnt + 4'd1);
         end
      end else if (hold1) begin
         gnt1_c        = 1'b1;
         last_grant_nx = 1'b1;
         if (bus.m1_lock) begin
            state_nx    = LOCK1;
            lock_cnt_nx = (lock_cnt == SAT_CNT) ? lock_cnt : CW'(lock_cnt + 4'd1);
         end
      end else if (req0_arb && (!req1_arb || last_grant)) begin
         gnt0_c        = 1'b1;
         last_grant_nx = 1'b0;
         if (bus.m0_lock) begin
            state_nx    = LOCK0;
            lock_cnt_nx = CW'(1);
         end
      end else if (req1_arb) begin
         gnt1_c        = 1'b1;
         last_grant_nx = 1'b1;
         if (bus.m1_lock) begin
            state_nx    = LOCK1;
            lock_cnt_nx = CW'(1);
         end
      end
   end

   // Grants are withheld while reset is asserted so nothing reaches memory.
   assign gnt0 = gnt0_c && !reset;
   assign gnt1 = gnt1_c && !reset;

   // Memory-side mux from the granted master.
   always_comb begin
      addr_sel  = '0;
      wdata_sel = '0;
      we_sel    = 1'b0;
      legal_sel = 1'b0;
      if (gnt0) begin
         addr_sel  = bus.m0_addr;
         wdata_sel = bus.m0_wdata;
         we_sel    = bus.m0_we;
         legal_sel = legal0;
      end else if (gnt1) begin
         addr_sel  = bus.m1_addr;
         wdata_sel = bus.m1_wdata;
         we_sel    = bus.m1_we;
         legal_sel = legal1;
      end
   end

   assign bus.mem_a  = addr_sel;
   assign bus.mem_wd = wdata_sel;
   assign bus.mem_we = we_sel && legal_sel;

   // Completion registers: one-cycle ack/err, read data captured at grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         err0   <= 1'b0;
         err1   <= 1'b0;
         rdata0 <= '0;
         rdata1 <= '0;
      end else begin
         ack0 <= gnt0;
         ack1 <= gnt1;
         err0 <= gnt0 && !legal0;
         err1 <= gnt1 && !legal1;
         if (gnt0) rdata0 <= (legal0 && !bus.m0_we) ? bus.mem_rd : '0;
         if (gnt1) rdata1 <= (legal1 && !bus.m1_we) ? bus.mem_rd : '0;
      end
   end

   assign bus.m0_gnt   = gnt0;
   assign bus.m1_gnt   = gnt1;
   assign bus.m0_ack   = ack0;
   assign bus.m1_ack   = ack1;
   assign bus.m0_err   = err0;
   assign bus.m1_err   = err1;
   assign bus.m0_rdata = rdata0;
   assign bus.m1_rdata = rdata1;
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter: MAX_LOCK, 4, max consecutive grants to one locked master while the other master waits (range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on posedge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: m0_req / m1_req  input  1  transaction request, held with attributes stable until granted.
REQ-005 SHALL have ports: m0_we / m1_we  input  1  1=write, 0=read.
REQ-006 SHALL have ports: m0_lock / m1_lock  input  1  request to keep ownership for the next transaction.
REQ-007 SHALL have ports: m0_addr, m0_wdata / m1_addr, m1_wdata  input  32 each  byte address, write data.
REQ-008 SHALL have ports: m0_gnt / m1_gnt  output  1  combinational, asserted in the cycle the request is issued to memory.
REQ-009 SHALL have ports: m0_ack, m0_err / m1_ack, m1_err  output  1 each  registered one-cycle completion pulse, error flag.
REQ-010 SHALL have ports: m0_rdata / m1_rdata  output  32  registered read data, valid with ack.
REQ-011 SHALL have ports: mem_we output 1, mem_a output 32, mem_wd output 32, mem_rd input 32  data memory side (combinational read).

Function
REQ-012 SHALL grant at most one master per cycle; gnt only when that master's req=1.
REQ-013 SHALL drive mem_a/mem_wd from the granted master; with no grant, mem_a=0, mem_wd=0, mem_we=0.
REQ-014 SHALL treat as legal: addr<0x100 with addr[1:0]=0 (RAM, R/W); 0xC000_0000 read-only (switches); 0xC000_0004 write-only (LEDs).
REQ-015 SHALL set mem_we = gnt & we & legal; an illegal access is still granted but never writes.
REQ-016 SHALL, in cycle after grant: ack=1 for granted master only; err=~legal; rdata = mem_rd sampled at grant for legal read, else 0.
REQ-017 SHALL hold ack/err at 0 and rdata at its last value when no completion occurs.
REQ-018 SHALL sustain one transaction per cycle (back-to-back grants to same master allowed).
REQ-019 SHALL use FSM states IDLE, LOCK0, LOCK1, plus last_grant pointer and lock counter (4 bits).
REQ-020 IDLE: single requester granted; both requesting -> grant master != last_grant (round-robin); last_grant updated on every grant.
REQ-021 IDLE -> LOCKi when master i granted with mi_lock=1; lock counter := 1.
REQ-022 LOCKi: only master i grantable; each grant increments counter (saturating at 15).
REQ-023 LOCKi -> IDLE when master i granted with lock=0, or mi_req=0 in any cycle (that cycle behaves as IDLE arbitration for the other master).
REQ-024 LOCKi: when counter = MAX_LOCK and other master requesting, master i SHALL NOT be granted; other master granted; transition per REQ-020/021 as from IDLE.
REQ-025 SHALL keep counter=0 in IDLE.

Reset
REQ-026 SHALL, on reset=1 at posedge: state IDLE, last_grant=1 (m0 wins first tie), counter 0, all ack/err 0, rdata 0.
REQ-027 SHALL suppress gnt and mem_we combinationally while reset=1; a transaction granted the cycle before reset produces no ack.

Verification
REQ-028 m0 read addr 0x08, RAM[2]=0x1234 -> m0_gnt same cycle, next cycle m0_ack=1, m0_err=0, m0_rdata=0x0000_1234.
REQ-029 both req continuously, no lock, after reset -> grants m0,m1,m0,m1 alternating, one ack per cycle to matching master.
REQ-030 m0 lock=1 writes 0x00,0x04,..., m1 req held, MAX_LOCK=4 -> four m0 grants, then m1 granted on 5th cycle; m0 granted next.
REQ-031 m1 write 0xDEAD to 0xC000_0004 -> mem_we=1, mem_a=0xC000_0004; m1 write to 0xC000_0000 -> mem_we=0, next cycle m1_err=1.
REQ-032 m0 read 0x102 (misaligned/out of range) -> mem_we=0, m0_ack=1, m0_err=1, m0_rdata=0.
REQ-033 reset asserted in LOCK1 with m1 granted -> no m1_ack next cycle, state IDLE, simultaneous reqs then grant m0 first.
